// File: rtl/mem_read_arbiter_if.sv
// Bundle of request, response and memory-port signals for the shared read arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_read_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_en;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*MASK_W-1:0] req_mask;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_done;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [MASK_W-1:0]         mem_mask;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_done;
  logic                      mem_valid;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  modport master (
    output req_en, req_addr, req_mask, mem_data, mem_done, mem_valid,
    input  rsp_data, rsp_done, rsp_valid, mem_en, mem_addr, mem_mask, grant, busy
  );

  modport slave (
    input  req_en, req_addr, req_mask, mem_data, mem_done, mem_valid,
    output rsp_data, rsp_done, rsp_valid, mem_en, mem_addr, mem_mask, grant, busy
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ requesters, with
// per-transaction grant hold, requester abort and timeout-to-error completion.
module mem_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  mem_read_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                abort_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [MASK_W-1:0]   mask_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REQ-1:0]  valid_q;

  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic                granted_en;
  logic                abort_now;
  logic                timeout_hit;

  // Lowest offset from last+1 wins; scanning from the far end lets the nearest overwrite.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] en,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (en[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    {pick_vld, pick_idx} = rr_pick(bus.req_en, last_q);
  end

  assign granted_en  = |(bus.req_en & grant_q);
  // A drop in the current cycle counts immediately, not only from the next cycle.
  assign abort_now   = abort_q | ~granted_en;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_vld) state_d = BUSY;
      BUSY: if (bus.mem_done || timeout_hit) state_d = abort_now ? IDLE : RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= NUM_REQ'(1) << pick_idx;
            last_q  <= pick_idx;
            addr_q  <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            mask_q  <= bus.req_mask[int'(pick_idx)*MASK_W +: MASK_W];
            cnt_q   <= '0;
            abort_q <= 1'b0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (!granted_en) abort_q <= 1'b1;
          if (bus.mem_done || timeout_hit) begin
            if (abort_now) begin
              grant_q <= '0;
            end else if (bus.mem_done) begin
              data_q  <= bus.mem_data;
              valid_q <= bus.mem_valid ? grant_q : '0;
            end else begin
              data_q  <= '0;
              valid_q <= '0;
            end
          end
        end
        RESP: grant_q <= '0;
        default: grant_q <= '0;
      endcase
    end
  end

  always_comb begin
    bus.mem_en    = (state_q == BUSY);
    bus.mem_addr  = addr_q;
    bus.mem_mask  = mask_q;
    bus.rsp_data  = data_q;
    bus.rsp_valid = valid_q;
    bus.rsp_done  = (state_q == RESP) ? grant_q : '0;
    bus.grant     = grant_q;
    bus.busy      = (state_q != IDLE);
  end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: two requesters, TIMEOUT=8, hand-computed expectations.
module tb_mem_read_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  mem_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.req_en    = '0;
    bus.mem_done  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Caller is in the first BUSY cycle; memory answers in the lat-th BUSY cycle.
  task automatic serve(input int lat, input logic [31:0] d, input logic v);
    repeat (lat - 1) step();
    bus.mem_done  = 1'b1;
    bus.mem_data  = d;
    bus.mem_valid = v;
    step();
    bus.mem_done  = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    rst          = 1'b0;
    bus.req_en   = '0;
    bus.req_addr = '0;
    bus.req_mask = '0;
    bus.mem_data = '0;
    bus.mem_done = 1'b0;
    bus.mem_valid = 1'b0;

    do_reset();
    chk_vec("rst_grant",  bus.grant,    0);
    chk_vec("rst_mem_en", bus.mem_en,   0);
    chk_vec("rst_busy",   bus.busy,     0);
    chk_vec("rst_done",   bus.rsp_done, 0);
    chk_vec("rst_data",   bus.rsp_data, 0);

    // Single request from requester 0, one-cycle memory
    bus.req_addr = {32'h0000_0300, 32'h0000_0100};
    bus.req_mask = {4'h3, 4'hF};
    bus.req_en   = 2'b01;
    step();
    chk_vec("t1_mem_en", bus.mem_en,   1);
    chk_vec("t1_addr",   bus.mem_addr, 32'h100);
    chk_vec("t1_mask",   bus.mem_mask, 4'hF);
    chk_vec("t1_grant",  bus.grant,    2'b01);
    serve(1, 32'hDEAD_BEEF, 1'b1);
    chk_vec("t1_done",   bus.rsp_done,  2'b01);
    chk_vec("t1_data",   bus.rsp_data,  32'hDEAD_BEEF);
    chk_vec("t1_valid",  bus.rsp_valid[0], 1);
    chk_vec("t1_men_lo", bus.mem_en,    0);
    bus.req_en = 2'b00;
    step();
    chk_vec("t1_done_once", bus.rsp_done, 0);
    chk_vec("t1_grant_clr", bus.grant,    0);

    // mem_done outside BUSY must be ignored
    bus.mem_done = 1'b1;
    step();
    bus.mem_done = 1'b0;
    chk_vec("idle_done_ign", bus.rsp_done, 0);
    chk_vec("idle_busy",     bus.busy,     0);

    // Both requesters held, memory answers in 2 cycles: 0,1,0,1
    do_reset();
    bus.req_en = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_vec("rr_grant", bus.grant,    (i % 2 == 0) ? 2'b01 : 2'b10);
      chk_vec("rr_addr",  bus.mem_addr, (i % 2 == 0) ? 32'h100 : 32'h300);
      chk_vec("rr_mask",  bus.mem_mask, (i % 2 == 0) ? 4'hF : 4'h3);
      serve(2, 32'hA000_0000 + i, 1'b1);
      chk_vec("rr_done",  bus.rsp_done, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk_vec("rr_data",  bus.rsp_data, 32'hA000_0000 + i);
      chk_vec("rr_valid", bus.rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk_vec("rr_idle_grant", bus.grant, 0);
    end
    bus.req_en = 2'b00;
    step();

    // Timeout on requester 1 after a normal transaction leaves nonzero data behind
    do_reset();
    bus.req_addr = {32'h0000_0400, 32'h0000_0500};
    bus.req_en   = 2'b10;
    step();
    serve(1, 32'hCAFE_F00D, 1'b1);
    chk_vec("to_pre_data", bus.rsp_data, 32'hCAFE_F00D);
    bus.req_en = 2'b00;
    step();
    bus.req_en = 2'b10;
    step();
    chk_vec("to_grant", bus.grant, 2'b10);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_vec("to_wait_en",   bus.mem_en,   1);
      chk_vec("to_wait_done", bus.rsp_done, 0);
    end
    step();
    chk_vec("to_done",   bus.rsp_done,  2'b10);
    chk_vec("to_valid",  bus.rsp_valid, 2'b00);
    chk_vec("to_data",   bus.rsp_data,  0);
    chk_vec("to_men_lo", bus.mem_en,    0);
    bus.req_en = 2'b00;
    step();
    bus.req_en = 2'b01;
    step();
    chk_vec("to_next_grant", bus.grant,    2'b01);
    chk_vec("to_next_addr",  bus.mem_addr, 32'h500);
    serve(1, 32'h0000_55AA, 1'b1);
    chk_vec("to_next_done",  bus.rsp_done, 2'b01);
    chk_vec("to_next_data",  bus.rsp_data, 32'h55AA);
    bus.req_en = 2'b00;
    step();

    // Requester 0 aborts in its 2nd BUSY cycle while requester 1 waits
    do_reset();
    bus.req_en = 2'b11;
    step();
    chk_vec("ab_grant", bus.grant, 2'b01);
    step();
    bus.req_en = 2'b10;
    step();
    chk_vec("ab_done_c3", bus.rsp_done, 0);
    step();
    chk_vec("ab_done_c4", bus.rsp_done, 0);
    serve(1, 32'h0000_0077, 1'b1);
    chk_vec("ab_done_end", bus.rsp_done, 0);
    chk_vec("ab_busy",     bus.busy,     0);
    chk_vec("ab_grant0",   bus.grant,    0);
    step();
    chk_vec("ab_next_grant", bus.grant,    2'b10);
    chk_vec("ab_no_done",    bus.rsp_done, 0);
    serve(1, 32'h0000_0088, 1'b1);
    chk_vec("ab_next_done", bus.rsp_done, 2'b10);
    bus.req_en = 2'b00;
    step();

    // Reset while BUSY, then both requesters compete
    do_reset();
    bus.req_en = 2'b11;
    step();
    step();
    chk_vec("mr_busy_pre", bus.mem_en, 1);
    rst = 1'b0;
    step();
    chk_vec("mr_mem_en", bus.mem_en,   0);
    chk_vec("mr_grant",  bus.grant,    0);
    chk_vec("mr_done",   bus.rsp_done, 0);
    chk_vec("mr_addr",   bus.mem_addr, 0);
    rst = 1'b1;
    step();
    chk_vec("mr_first", bus.grant, 2'b01);
    serve(1, 32'h0000_0099, 1'b1);
    chk_vec("mr_resp", bus.rsp_done, 2'b01);
    bus.req_en = 2'b00;
    step();

    // Memory completes with mem_valid low
    do_reset();
    bus.req_en = 2'b01;
    step();
    serve(1, 32'h0000_1234, 1'b0);
    chk_vec("nv_done",  bus.rsp_done,  2'b01);
    chk_vec("nv_valid", bus.rsp_valid, 2'b00);
    chk_vec("nv_data",  bus.rsp_data,  32'h1234);
    bus.req_en = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
